// File: rtl/lsu.sv
// Load/store unit: splits an RV32 LB/LH/LW/LBU/LHU/SB/SH/SW access into
// BUS_BYTES-wide memory beats and assembles/extends load results.
// Optional build macro: LSU_MISALIGN_TRAP_EN (fault misaligned accesses
// instead of executing them as multi-beat transfers).
module lsu #(
   parameter int unsigned BUS_BYTES = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic                   i_is_store,
   input  logic [2:0]             i_funct3,
   input  logic [31:0]            i_base,
   input  logic [11:0]            i_offset,
   input  logic [31:0]            i_store_data,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_fault,
   output logic [31:0]            o_load_data,
   output logic                   o_mem_req,
   output logic                   o_mem_write,
   output logic [31:0]            o_mem_addr,
   output logic [BUS_BYTES*8-1:0] o_mem_wdata,
   input  logic                   i_mem_ack,
   input  logic [BUS_BYTES*8-1:0] i_mem_rdata
);

   localparam int unsigned BW        = BUS_BYTES * 8;
   localparam int unsigned BUS_SHIFT = (BUS_BYTES == 4) ? 2 : ((BUS_BYTES == 2) ? 1 : 0);
`ifdef LSU_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  beat_q, beat_nxt;
   logic [2:0]  nbeats_q, nbeats_nxt;
   logic [2:0]  size_q, size_nxt;
   logic [2:0]  funct3_q, funct3_nxt;
   logic [31:0] store_data_q, store_data_nxt;
   logic [31:0] raw_q, raw_nxt;

   logic          busy_nxt, done_nxt, fault_nxt, mem_req_nxt, mem_write_nxt;
   logic [31:0]   load_data_nxt, mem_addr_nxt;
   logic [BW-1:0] mem_wdata_nxt;

   logic [31:0] ea_c;
   logic [2:0]  size_c, nbeats_c, shifted_c;
   logic        legal_c, misalign_c;

   // Write lanes for beat k; lanes past the access size are zero.
   function automatic logic [BW-1:0] beat_wdata(input logic [1:0] k, input logic [2:0] size,
                                                input logic [31:0] data);
      logic [BW-1:0] w;
      logic [3:0]    idx;
      w = '0;
      for (int unsigned j = 0; j < BUS_BYTES; j++) begin
         idx = 4'(32'(k) * BUS_BYTES + j);
         if (idx < {1'b0, size}) w[j*8 +: 8] = data[idx[1:0]*8 +: 8];
      end
      return w;
   endfunction

   // Merge the lanes of read beat k into the raw load word.
   function automatic logic [31:0] merge_lanes(input logic [31:0] raw, input logic [1:0] k,
                                               input logic [2:0] size, input logic [BW-1:0] rd);
      logic [31:0] r;
      logic [3:0]  idx;
      r = raw;
      for (int unsigned j = 0; j < BUS_BYTES; j++) begin
         idx = 4'(32'(k) * BUS_BYTES + j);
         if (idx < {1'b0, size}) r[idx[1:0]*8 +: 8] = rd[j*8 +: 8];
      end
      return r;
   endfunction

   // Sign/zero extension of the assembled load word.
   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
      case (f3)
         3'd0:    return {{24{r[7]}}, r[7:0]};
         3'd1:    return {{16{r[15]}}, r[15:0]};
         3'd4:    return {24'd0, r[7:0]};
         3'd5:    return {16'd0, r[15:0]};
         default: return r;
      endcase
   endfunction

   // Command decode: effective address, size, beat count, legality, alignment.
   always_comb begin
      ea_c = i_base + {{20{i_offset[11]}}, i_offset};
      case (i_funct3[1:0])
         2'd0:    size_c = 3'd1;
         2'd1:    size_c = 3'd2;
         default: size_c = 3'd4;
      endcase
      shifted_c  = 3'(size_c >> BUS_SHIFT);
      nbeats_c   = (shifted_c == 3'd0) ? 3'd1 : shifted_c;
      legal_c    = i_is_store ? (i_funct3 inside {3'd0, 3'd1, 3'd2})
                              : (i_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      misalign_c = ((i_funct3[1:0] == 2'd1) && ea_c[0]) ||
                   ((i_funct3[1:0] == 2'd2) && (ea_c[1:0] != 2'd0));
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt      = state;
      beat_nxt       = beat_q;
      nbeats_nxt     = nbeats_q;
      size_nxt       = size_q;
      funct3_nxt     = funct3_q;
      store_data_nxt = store_data_q;
      raw_nxt        = raw_q;
      busy_nxt       = o_busy;
      done_nxt       = 1'b0;
      fault_nxt      = o_fault;
      load_data_nxt  = o_load_data;
      mem_req_nxt    = o_mem_req;
      mem_write_nxt  = o_mem_write;
      mem_addr_nxt   = o_mem_addr;
      mem_wdata_nxt  = o_mem_wdata;

      case (state)
         IDLE: begin
            if (i_start) begin
               funct3_nxt     = i_funct3;
               size_nxt       = size_c;
               nbeats_nxt     = nbeats_c;
               store_data_nxt = i_store_data;
               beat_nxt       = 2'd0;
               raw_nxt        = 32'd0;
               busy_nxt       = 1'b1;
               if (legal_c && !(TRAP_EN && misalign_c)) begin
                  state_nxt     = XFER;
                  fault_nxt     = 1'b0;
                  mem_req_nxt   = 1'b1;
                  mem_write_nxt = i_is_store;
                  mem_addr_nxt  = ea_c;
                  mem_wdata_nxt = beat_wdata(2'd0, size_c, i_store_data);
               end else begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  fault_nxt = 1'b1;
               end
            end
         end
         XFER: begin
            if (i_mem_ack) begin
               raw_nxt = merge_lanes(raw_q, beat_q, size_q, i_mem_rdata);
               if ({1'b0, beat_q} == nbeats_q - 3'd1) begin
                  state_nxt     = DONE;
                  done_nxt      = 1'b1;
                  mem_req_nxt   = 1'b0;
                  mem_write_nxt = 1'b0;
                  mem_wdata_nxt = '0;
                  if (!o_mem_write) load_data_nxt = extend(funct3_q, raw_nxt);
               end else begin
                  beat_nxt      = beat_q + 2'd1;
                  mem_addr_nxt  = o_mem_addr + 32'(BUS_BYTES);
                  mem_wdata_nxt = beat_wdata(beat_q + 2'd1, size_q, store_data_q);
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            fault_nxt = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         beat_q       <= 2'd0;
         nbeats_q     <= 3'd0;
         size_q       <= 3'd0;
         funct3_q     <= 3'd0;
         store_data_q <= 32'd0;
         raw_q        <= 32'd0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_fault      <= 1'b0;
         o_load_data  <= 32'd0;
         o_mem_req    <= 1'b0;
         o_mem_write  <= 1'b0;
         o_mem_addr   <= 32'd0;
         o_mem_wdata  <= '0;
      end else begin
         state        <= state_nxt;
         beat_q       <= beat_nxt;
         nbeats_q     <= nbeats_nxt;
         size_q       <= size_nxt;
         funct3_q     <= funct3_nxt;
         store_data_q <= store_data_nxt;
         raw_q        <= raw_nxt;
         o_busy       <= busy_nxt;
         o_done       <= done_nxt;
         o_fault      <= fault_nxt;
         o_load_data  <= load_data_nxt;
         o_mem_req    <= mem_req_nxt;
         o_mem_write  <= mem_write_nxt;
         o_mem_addr   <= mem_addr_nxt;
         o_mem_wdata  <= mem_wdata_nxt;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: three instances (BUS_BYTES = 1, 2, 4) share one
// stimulus bus; a byte-addressed memory model answers the selected instance.
module tb_lsu;

   logic        clk, rst, start, is_store, ack;
   logic [2:0]  funct3;
   logic [31:0] base, sdata, rdata;
   logic [11:0] offset;
   int          sel;

   logic        busy_a [3];
   logic        done_a [3];
   logic        fault_a[3];
   logic        req_a  [3];
   logic        wr_a   [3];
   logic [31:0] ld_a   [3];
   logic [31:0] addr_a [3];
   logic [31:0] wd_a   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned BB = 1 << g;
      logic [BB*8-1:0] wd, rd;
      assign rd      = rdata[BB*8-1:0];
      assign wd_a[g] = 32'(wd);
      lsu #(.BUS_BYTES(BB)) u_dut (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_start     (start && (sel == g)),
         .i_is_store  (is_store),
         .i_funct3    (funct3),
         .i_base      (base),
         .i_offset    (offset),
         .i_store_data(sdata),
         .o_busy      (busy_a[g]),
         .o_done      (done_a[g]),
         .o_fault     (fault_a[g]),
         .o_load_data (ld_a[g]),
         .o_mem_req   (req_a[g]),
         .o_mem_write (wr_a[g]),
         .o_mem_addr  (addr_a[g]),
         .o_mem_wdata (wd),
         .i_mem_ack   (ack && (sel == g)),
         .i_mem_rdata (rd)
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   logic [7:0]  mem [logic [31:0]];
   logic [31:0] log_addr[8];
   logic [31:0] log_wd  [8];
   int          nb, lat, stab_err;
   logic        d_fault;
   logic [31:0] d_ld, exp_ld0;
   int          stray_done;

   function automatic logic [7:0] rdb(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one command on instance s and act as memory with 'waits' stall cycles per beat.
   task automatic run_cmd(input int s, input logic st, input logic [2:0] f3, input logic [31:0] b,
                          input logic [11:0] off, input logic [31:0] sd, input int waits);
      logic [31:0] h_addr, h_wd, a;
      logic        h_wr, held;
      int          wcnt;
      sel = s;
      @(negedge clk);
      start = 1'b1; is_store = st; funct3 = f3; base = b; offset = off; sdata = sd;
      @(negedge clk);
      start = 1'b0;
      nb = 0; lat = 0; stab_err = 0; held = 1'b0; wcnt = 0;
      h_addr = '0; h_wd = '0; h_wr = 1'b0; d_fault = 1'b0; d_ld = '0;
      for (int c = 1; c <= 60; c++) begin
         ack = 1'b0;
         if (done_a[s]) begin
            lat = c; d_fault = fault_a[s]; d_ld = ld_a[s];
            break;
         end
         if (req_a[s]) begin
            if (held && (addr_a[s] !== h_addr || wd_a[s] !== h_wd || wr_a[s] !== h_wr))
               stab_err++;
            held = 1'b1; h_addr = addr_a[s]; h_wd = wd_a[s]; h_wr = wr_a[s];
            if (wcnt == waits) begin
               a     = addr_a[s];
               ack   = 1'b1;
               rdata = {rdb(a + 32'd3), rdb(a + 32'd2), rdb(a + 32'd1), rdb(a)};
               if (wr_a[s])
                  for (int j = 0; j < (1 << s); j++) mem[a + 32'(j)] = wd_a[s][j*8 +: 8];
               if (nb < 8) begin log_addr[nb] = a; log_wd[nb] = wd_a[s]; end
               nb++;
               wcnt = 0; held = 1'b0;
            end else begin
               wcnt++;
            end
         end
         @(negedge clk);
      end
      ack = 1'b0;
      if (lat == 0) begin
         errors++;
         $display("FAIL timeout: no o_done within 60 cycles on instance %0d", s);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; base = '0; offset = '0;
      sdata = '0; ack = 1'b0; rdata = '0; sel = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy",  32'(busy_a[0]), 32'd0);
      chk("rst_done",  32'(done_a[0]), 32'd0);
      chk("rst_req",   32'(req_a[0]),  32'd0);
      chk("rst_addr",  addr_a[2],      32'd0);
      chk("rst_ld",    ld_a[1],        32'd0);
      chk("rst_wdata", wd_a[2],        32'd0);
      rst = 1'b0;

      // LW over a byte bus: four beats, done on cycle 5
      mem[32'h104] = 8'h78; mem[32'h105] = 8'h56; mem[32'h106] = 8'h34; mem[32'h107] = 8'h12;
      run_cmd(0, 1'b0, 3'd2, 32'h100, 12'h004, 32'h0, 0);
      chk("lw_lat",   32'(lat),     32'd5);
      chk("lw_beats", 32'(nb),      32'd4);
      chk("lw_a0",    log_addr[0],  32'h104);
      chk("lw_a3",    log_addr[3],  32'h107);
      chk("lw_data",  d_ld,         32'h12345678);
      chk("lw_fault", 32'(d_fault), 32'd0);
      repeat (2) @(negedge clk);
      chk("lw_hold",  ld_a[0],      32'h12345678);
      chk("lw_idle",  32'(busy_a[0]), 32'd0);

      // LB / LBU on a word bus; upper lanes must be ignored
      mem[32'h300] = 8'h80; mem[32'h301] = 8'hFF;
      run_cmd(2, 1'b0, 3'd0, 32'h300, 12'h000, 32'h0, 0);
      chk("lb_lat",   32'(lat), 32'd2);
      chk("lb_beats", 32'(nb),  32'd1);
      chk("lb_data",  d_ld,     32'hFFFFFF80);
      run_cmd(2, 1'b0, 3'd4, 32'h300, 12'h000, 32'h0, 0);
      chk("lbu_data", d_ld,     32'h00000080);

      // SW over a halfword bus with negative offset and two wait cycles per beat
      run_cmd(1, 1'b1, 3'd2, 32'h200, 12'hFFE, 32'hAABBCCDD, 2);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("sw_fault", 32'(d_fault), 32'd1);
      chk("sw_beats", 32'(nb),      32'd0);
      chk("sw_lat",   32'(lat),     32'd1);
`else
      chk("sw_fault", 32'(d_fault), 32'd0);
      chk("sw_beats", 32'(nb),      32'd2);
      chk("sw_lat",   32'(lat),     32'd7);
      chk("sw_a0",    log_addr[0],  32'h1FE);
      chk("sw_w0",    log_wd[0],    32'h0000CCDD);
      chk("sw_a1",    log_addr[1],  32'h200);
      chk("sw_w1",    log_wd[1],    32'h0000AABB);
      chk("sw_mem",   32'(rdb(32'h1FF)), 32'h000000CC);
`endif
      chk("sw_stable", 32'(stab_err), 32'd0);

      // SH on a word bus: lanes beyond size driven zero
      run_cmd(2, 1'b1, 3'd1, 32'h400, 12'h000, 32'hDEADBEEF, 1);
      chk("sh_beats", 32'(nb),   32'd1);
      chk("sh_wdata", log_wd[0], 32'h0000BEEF);

      // EA computation wraps modulo 2^32
      mem[32'h4] = 8'h01; mem[32'h5] = 8'h02; mem[32'h6] = 8'h03; mem[32'h7] = 8'h04;
      run_cmd(2, 1'b0, 3'd2, 32'hFFFFFFFC, 12'h008, 32'h0, 0);
      chk("wrap_addr", log_addr[0], 32'h4);
      chk("wrap_data", d_ld,        32'h04030201);

      // Misaligned LH at 0x101 on a byte bus
      mem[32'h101] = 8'h34; mem[32'h102] = 8'h92;
      run_cmd(0, 1'b0, 3'd1, 32'h100, 12'h001, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      exp_ld0 = 32'h12345678;
      chk("mis_fault", 32'(d_fault), 32'd1);
      chk("mis_beats", 32'(nb),      32'd0);
`else
      exp_ld0 = 32'hFFFF9234;
      chk("mis_fault", 32'(d_fault), 32'd0);
      chk("mis_beats", 32'(nb),      32'd2);
      chk("mis_a1",    log_addr[1],  32'h102);
`endif
      chk("mis_data", d_ld, exp_ld0);

      // Illegal funct3: store 5 and load 3
      run_cmd(0, 1'b1, 3'd5, 32'h0, 12'h000, 32'h0, 0);
      chk("ill_lat",   32'(lat),     32'd1);
      chk("ill_fault", 32'(d_fault), 32'd1);
      chk("ill_beats", 32'(nb),      32'd0);
      chk("ill_ld",    d_ld,         exp_ld0);
      run_cmd(1, 1'b0, 3'd3, 32'h0, 12'h000, 32'h0, 0);
      chk("ill3_fault", 32'(d_fault), 32'd1);

      // Ack while idle is ignored
      sel = 0; ack = 1'b1;
      repeat (2) @(negedge clk);
      ack = 1'b0;
      chk("idle_ack_busy", 32'(busy_a[0]), 32'd0);
      chk("idle_ack_done", 32'(done_a[0]), 32'd0);

      // Reset during the second beat of LW abandons the command
      sel = 0;
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; funct3 = 3'd2; base = 32'h104; offset = 12'h000;
      @(negedge clk);
      start = 1'b0; ack = 1'b1; rdata = 32'h00000078;
      @(negedge clk);
      ack = 1'b0;
      chk("rmid_addr", addr_a[0], 32'h105);
      rst = 1'b1;
      @(negedge clk);
      chk("rmid_req",  32'(req_a[0]),  32'd0);
      chk("rmid_busy", 32'(busy_a[0]), 32'd0);
      chk("rmid_done", 32'(done_a[0]), 32'd0);
      rst = 1'b0;
      stray_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done_a[0]) stray_done++;
      end
      chk("rmid_nodone", 32'(stray_done), 32'd0);
      run_cmd(0, 1'b1, 3'd0, 32'h500, 12'h000, 32'h0000005A, 0);
      chk("sb_lat",   32'(lat),     32'd2);
      chk("sb_fault", 32'(d_fault), 32'd0);
      chk("sb_wdata", log_wd[0],    32'h5A);
      chk("sb_mem",   32'(rdb(32'h500)), 32'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
